// File: rtl/pair_stream_sequencer_if.sv
// Producer write port and bfm operand stream of the ping-pong pair sequencer.
// Both sides use valid/ready: a transfer happens on a posedge where valid && ready are both high;
// the source holds valid and data stable until that edge, and ready never depends on valid.
interface pair_stream_sequencer_if #(
  parameter int ITEM_WIDTH = 8,
  parameter int CNT_W      = 32
);
  logic                  wr_valid_i;
  logic                  wr_ready_o;
  logic [ITEM_WIDTH-1:0] wr_a_i;
  logic [ITEM_WIDTH-1:0] wr_b_i;
  logic                  enable_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [ITEM_WIDTH-1:0] a_o;
  logic [ITEM_WIDTH-1:0] b_o;
  logic                  out_last_o;
  logic                  pkt_done_o;
  logic [CNT_W-1:0]      pkt_cnt_o;
  logic                  busy_o;
  logic [1:0]            state_dbg;

  modport master (
    output wr_valid_i, wr_a_i, wr_b_i, enable_i, out_ready_i,
    input  wr_ready_o, out_valid_o, a_o, b_o, out_last_o, pkt_done_o, pkt_cnt_o, busy_o,
           state_dbg
  );

  modport slave (
    input  wr_valid_i, wr_a_i, wr_b_i, enable_i, out_ready_i,
    output wr_ready_o, out_valid_o, a_o, b_o, out_last_o, pkt_done_o, pkt_cnt_o, busy_o,
           state_dbg
  );
endinterface

// File: rtl/pair_stream_sequencer.sv
// Ping-pong packet buffer: one bank of NUM operand pairs fills from the producer while the
// other replays onto the bfm operand stream under valid/ready flow control.
module pair_stream_sequencer #(
  parameter int ITEM_WIDTH = 8,
  parameter int NUM        = 1000,
  parameter int CNT_W      = 32
) (
  input logic                     clk_i,
  input logic                     reset_ni,
  pair_stream_sequencer_if.slave  bus
);
  localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DRAIN = 2'd2} state_t;

  state_t                    state, state_next;
  logic [1:0]                full;
  logic                      wbank, rbank;
  logic [IDX_W-1:0]          widx, ridx;
  logic [2*ITEM_WIDTH-1:0]   mem [2][NUM];
  logic                      out_valid, out_last, pkt_done;
  logic [ITEM_WIDTH-1:0]     a_q, b_q;
  logic [CNT_W-1:0]          pkt_cnt;
  logic                      wr_ready, wr_fire, wr_last;
  logic                      accept, start, load, drain_done;

  assign wr_ready = !full[wbank];
  assign wr_fire  = bus.wr_valid_i && wr_ready;
  assign wr_last  = wr_fire && (widx == LAST_IDX);
  assign accept   = out_valid && bus.out_ready_i;

  always_comb begin
    state_next = state;
    start      = 1'b0;
    load       = 1'b0;
    drain_done = 1'b0;
    case (state)
      IDLE: begin
        if (full[rbank] && bus.enable_i) begin
          start      = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (bus.enable_i && (!out_valid || bus.out_ready_i)) begin
          load = 1'b1;
          if (ridx == LAST_IDX) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (accept) begin
          drain_done = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bank storage is deliberately left out of reset; full[] alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_fire) mem[wbank][widx] <= {bus.wr_a_i, bus.wr_b_i};
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state     <= IDLE;
      full      <= 2'b00;
      wbank     <= 1'b0;
      rbank     <= 1'b0;
      widx      <= '0;
      ridx      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      pkt_done  <= 1'b0;
      pkt_cnt   <= '0;
    end else begin
      state    <= state_next;
      pkt_done <= drain_done;
      if (wr_fire) begin
        if (widx == LAST_IDX) begin
          widx  <= '0;
          wbank <= ~wbank;
        end else begin
          widx <= widx + 1'b1;
        end
      end
      // The writer never targets a full bank, so set and clear always hit different bits.
      if (wr_last)    full[wbank] <= 1'b1;
      if (drain_done) full[rbank] <= 1'b0;
      if (start) ridx <= '0;
      if (load) begin
        {a_q, b_q} <= mem[rbank][ridx];
        out_valid  <= 1'b1;
        out_last   <= (ridx == LAST_IDX);
        ridx       <= (ridx == LAST_IDX) ? '0 : ridx + 1'b1;
      end else if (accept) begin
        out_valid <= 1'b0;
        if (drain_done) begin
          out_last <= 1'b0;
          rbank    <= ~rbank;
          pkt_cnt  <= pkt_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.wr_ready_o  = wr_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.a_o         = a_q;
  assign bus.b_o         = b_q;
  assign bus.out_last_o  = out_last;
  assign bus.pkt_done_o  = pkt_done;
  assign bus.pkt_cnt_o   = pkt_cnt;
  assign bus.busy_o      = (state != IDLE);
  assign bus.state_dbg   = state;
endmodule
